writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue.sv | 128 ++++++++++++
 tb/tb_writeback_queue.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// Writeback queue: merges MEM and ALU results into one in-order FIFO and
// drains one entry per cycle into registered register-file write outputs.
// Also answers a combinational "is a write pending to this register" query.
//
// Handshake: a source transfers on a rising edge when its valid and ready are
// both 1. Ready is decoded from the registered count only, so a source may
// hold valid high waiting for ready, and ready never depends on any valid
// input or on the pop in the same cycle.
module writeback_queue #(
   parameter int bits_palavra  = 32,
   parameter int end_registros = 4,
   parameter int depth         = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      mem_valid,
   output logic                      mem_ready,
   input  logic [end_registros-1:0]  mem_addr,
   input  logic [bits_palavra-1:0]   mem_data,
   input  logic                      alu_valid,
   output logic                      alu_ready,
   input  logic [end_registros-1:0]  alu_addr,
   input  logic [bits_palavra-1:0]   alu_data,
   output logic                      wr_enable,
   output logic [end_registros-1:0]  wr_addr,
   output logic [bits_palavra-1:0]   wr_data,
   input  logic [end_registros-1:0]  query_addr,
   output logic                      query_hit,
   output logic [$clog2(depth):0]    count
);

   localparam int PW = $clog2(depth);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_M1 = CW'(depth - 1);
   localparam logic [CW-1:0] DEPTH_M2 = CW'(depth - 2);

   // Entry storage; occupancy is tracked by pointers/count, so no reset needed.
   logic [end_registros-1:0] addr_q [depth];
   logic [bits_palavra-1:0]  data_q [depth];

   logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]            count_q, count_d;
   logic                     wr_enable_q, wr_enable_d;
   logic [end_registros-1:0] wr_addr_q, wr_addr_d;
   logic [bits_palavra-1:0]  wr_data_q, wr_data_d;

   logic                     push_mem;
   logic                     push_alu;
   logic                     pop;
   logic [PW-1:0]            alu_slot;
   logic [PW-1:0]            offs [depth];
   logic                     hit;

   // Readies come from registered count only; forced low while in reset.
   assign mem_ready = reset & (count_q <= DEPTH_M1);
   assign alu_ready = reset & (count_q <= DEPTH_M2);

   assign wr_enable = wr_enable_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign count     = count_q;

   // Next-state: pushes (MEM first, ALU behind it), single pop of the head.
   always_comb begin
      push_mem    = mem_valid & mem_ready;
      push_alu    = alu_valid & alu_ready;
      pop         = (count_q != '0);
      alu_slot    = push_mem ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
      wr_ptr_d    = wr_ptr_q + PW'(push_mem) + PW'(push_alu);
      rd_ptr_d    = rd_ptr_q + PW'(pop);
      count_d     = count_q + CW'(push_mem) + CW'(push_alu) - CW'(pop);
      wr_enable_d = pop;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      if (pop) begin
         wr_addr_d = addr_q[rd_ptr_q];
         wr_data_d = data_q[rd_ptr_q];
      end
   end

   // Control and output registers, cleared asynchronously.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         wr_enable_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         wr_enable_q <= wr_enable_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   // Entry storage writes; the ALU entry lands in the slot after MEM's.
   always_ff @(posedge clock) begin
      if (push_mem) begin
         addr_q[wr_ptr_q] <= mem_addr;
         data_q[wr_ptr_q] <= mem_data;
      end
      if (push_alu) begin
         addr_q[alu_slot] <= alu_addr;
         data_q[alu_slot] <= alu_data;
      end
   end

   // Hazard check: any occupied slot or the word currently on wr_* matches.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < depth; i++) begin
         offs[i] = PW'(i) - rd_ptr_q;
         if ((CW'(offs[i]) < count_q) && (addr_q[i] == query_addr)) begin
            hit = 1'b1;
         end
      end
      if (wr_enable_q && (wr_addr_q == query_addr)) begin
         hit = 1'b1;
      end
      query_hit = reset & hit;
   end

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: a queue-based model of the writeback FIFO is
// advanced on every rising edge and compared with the DUT on every falling
// edge; directed sequences add hand-computed literal expectations.
module tb_writeback_queue;

   localparam int BW    = 32;
   localparam int AW    = 4;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   logic          mem_valid, alu_valid;
   logic          mem_ready, alu_ready;
   logic [AW-1:0] mem_addr, alu_addr, query_addr, wr_addr;
   logic [BW-1:0] mem_data, alu_data, wr_data;
   logic          wr_enable, query_hit;
   logic [CW-1:0] count;

   writeback_queue #(.bits_palavra(BW), .end_registros(AW), .depth(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
      .query_addr(query_addr), .query_hit(query_hit), .count(count)
   );

   // ---------------- model / scoreboard ----------------
   typedef struct packed {
      logic [AW-1:0] a;
      logic [BW-1:0] d;
   } ent_t;

   ent_t          model_q[$];
   logic          exp_we = 1'b0;
   logic [AW-1:0] exp_wa = '0;
   logic [BW-1:0] exp_wd = '0;
   int            n_vec = 0;
   int            n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic model_hit(input logic [AW-1:0] qa);
      if (!reset) return 1'b0;
      foreach (model_q[i]) if (model_q[i].a == qa) return 1'b1;
      return exp_we && (exp_wa == qa);
   endfunction

   // One rising edge: the pre-edge head is written out, then accepted pushes
   // join the back of the queue, MEM before ALU.
   task automatic model_edge();
      bit   mr, ar;
      ent_t head;
      if (!reset) return;
      mr = (model_q.size() < DEPTH);
      ar = (model_q.size() < DEPTH - 1);
      if (model_q.size() > 0) begin
         head   = model_q.pop_front();
         exp_we = 1'b1;
         exp_wa = head.a;
         exp_wd = head.d;
      end else begin
         exp_we = 1'b0;
      end
      if (mem_valid && mr) model_q.push_back(ent_t'{a: mem_addr, d: mem_data});
      if (alu_valid && ar) model_q.push_back(ent_t'{a: alu_addr, d: alu_data});
   endtask

   task automatic compare();
      check("mem_ready", 64'(mem_ready), 64'(reset && (model_q.size() < DEPTH)));
      check("alu_ready", 64'(alu_ready), 64'(reset && (model_q.size() < DEPTH - 1)));
      check("count",     64'(count),     64'(model_q.size()));
      check("wr_enable", 64'(wr_enable), 64'(exp_we));
      check("wr_addr",   64'(wr_addr),   64'(exp_wa));
      check("wr_data",   64'(wr_data),   64'(exp_wd));
      check("query_hit", 64'(query_hit), 64'(model_hit(query_addr)));
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clock);
      model_edge();
      @(negedge clock);
      compare();
   endtask

   task automatic idle();
      mem_valid = 1'b0;
      alu_valid = 1'b0;
   endtask

   task automatic drain();
      idle();
      repeat (DEPTH + 2) step();
   endtask

   ent_t got_q[$];

   initial begin
      idle();
      mem_addr = '0; mem_data = '0; alu_addr = '0; alu_data = '0; query_addr = '0;

      // Reset state, held with reset low.
      #1;
      check("rst_wr_enable", 64'(wr_enable), 64'(0));
      check("rst_count",     64'(count),     64'(0));
      check("rst_mem_ready", 64'(mem_ready), 64'(0));
      check("rst_alu_ready", 64'(alu_ready), 64'(0));
      check("rst_query_hit", 64'(query_hit), 64'(0));
      repeat (2) @(negedge clock);
      compare();
      reset = 1'b1;
      #1;
      check("rel_mem_ready", 64'(mem_ready), 64'(1));
      check("rel_alu_ready", 64'(alu_ready), 64'(1));
      step();

      // Single ALU write to register 5.
      alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 32'h0000_00AA; query_addr = 4'd5;
      step();
      check("single_count1", 64'(count), 64'(1));
      check("single_we0",    64'(wr_enable), 64'(0));
      check("single_hit",    64'(query_hit), 64'(1));
      idle();
      step();
      check("single_we",    64'(wr_enable), 64'(1));
      check("single_addr",  64'(wr_addr),   64'(5));
      check("single_data",  64'(wr_data),   64'(32'hAA));
      check("single_count0", 64'(count),    64'(0));
      step();
      check("single_we_off", 64'(wr_enable), 64'(0));

      // Dual push, same address: MEM lands first, ALU last.
      mem_valid = 1'b1; mem_addr = 4'd3; mem_data = 32'h11;
      alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'h22;
      step();
      check("dual_count2", 64'(count), 64'(2));
      idle();
      step();
      check("dual_w1", 64'({wr_enable, wr_addr, wr_data}), 64'({1'b1, 4'd3, 32'h11}));
      check("dual_count1", 64'(count), 64'(1));
      step();
      check("dual_w2", 64'({wr_enable, wr_addr, wr_data}), 64'({1'b1, 4'd3, 32'h22}));
      check("dual_count0", 64'(count), 64'(0));
      step();
      check("dual_we_off", 64'(wr_enable), 64'(0));

      // Hazard on register 7.
      mem_valid = 1'b1; mem_addr = 4'd7; mem_data = 32'h77; query_addr = 4'd7;
      step();
      idle();
      check("haz_hit_q", 64'(query_hit), 64'(1));
      query_addr = 4'd6; #1;
      check("haz_miss",  64'(query_hit), 64'(0));
      query_addr = 4'd7; #1;
      step();
      check("haz_hit_wr", 64'({wr_enable, query_hit}), 64'(2'b11));
      step();
      check("haz_clear", 64'(query_hit), 64'(0));

      // Fill: both sources valid every cycle.
      for (int i = 0; i < 10; i++) begin
         mem_valid = 1'b1; mem_addr = AW'($urandom_range(0, 15)); mem_data = $urandom;
         alu_valid = 1'b1; alu_addr = AW'($urandom_range(0, 15)); alu_data = $urandom;
         step();
         check("fill_max", 64'(count <= CW'(DEPTH)), 64'(1));
         if (count >= CW'(3)) check("fill_alu_rdy", 64'(alu_ready), 64'(0));
         if (count == CW'(4)) check("fill_mem_rdy", 64'(mem_ready), 64'(0));
      end
      drain();

      // Wrap: ten single pushes with addresses 0..9.
      got_q.delete();
      for (int i = 0; i < 10 + DEPTH; i++) begin
         idle();
         if (i < 10) begin
            mem_valid = 1'b1; mem_addr = AW'(i); mem_data = $urandom;
         end
         step();
         if (wr_enable) got_q.push_back(ent_t'{a: wr_addr, d: wr_data});
      end
      check("wrap_count", 64'(got_q.size()), 64'(10));
      foreach (got_q[k]) check("wrap_order", 64'(got_q[k].a), 64'(k));

      // Reset mid-operation with three entries pending.
      mem_valid = 1'b1; mem_addr = 4'd9;  mem_data = 32'h9;
      alu_valid = 1'b1; alu_addr = 4'd10; alu_data = 32'hA;
      step();
      mem_data = 32'h19; alu_data = 32'h1A;
      step();
      check("mid_count3", 64'(count), 64'(3));
      idle();
      query_addr = 4'd10;
      @(posedge clock);
      model_edge();
      #2 reset = 1'b0;
      #1;
      check("mid_we",        64'(wr_enable), 64'(0));
      check("mid_count",     64'(count),     64'(0));
      check("mid_mem_ready", 64'(mem_ready), 64'(0));
      check("mid_alu_ready", 64'(alu_ready), 64'(0));
      check("mid_hit",       64'(query_hit), 64'(0));
      model_q.delete();
      exp_we = 1'b0; exp_wa = '0; exp_wd = '0;
      @(negedge clock);
      compare();
      repeat (2) step();
      reset = 1'b1;
      #1;
      check("mid_rel_ready", 64'({mem_ready, alu_ready}), 64'(2'b11));
      for (int i = 0; i < 5; i++) begin
         step();
         check("mid_no_stale", 64'(wr_enable), 64'(0));
      end

      // Randomized traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         mem_valid  = ($urandom_range(0, 2) != 0);
         alu_valid  = ($urandom_range(0, 1) != 0);
         mem_addr   = AW'($urandom_range(0, 7));
         alu_addr   = AW'($urandom_range(0, 7));
         mem_data   = $urandom;
         alu_data   = $urandom;
         query_addr = AW'($urandom_range(0, 7));
         step();
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
